regfile_bypass: RTL and testbench
=================================

// Module: regfile_bypass
// PURPOSE
//  Parametrised GPR file for the ID stage: NREAD combinational read ports, one registered write port,
//  NFWD-deep priority bypass from later pipeline stages, plus same-cycle WB write-through.
//  Adds a load scoreboard and stall request for load-use hazards, and a stall-cycle perf counter.
//  Sits between ID (readers), EX/MEM (forward sources) and WB (writer).
// PARAMETERS
//  DATA_W   32  register width
//  ADDR_W   5   register index width; NREG = 2**ADDR_W, register 0 hard-wired to zero
//  NREAD    2   number of read ports
//  NFWD     2   number of forward sources; index 0 = youngest (EX), highest priority
// PORTS
//  clk         in   1               clock, all state on rising edge
//  resetn      in   1               asynchronous active-low reset
//  raddr       in   NREAD*ADDR_W    read addresses, port p at [p*ADDR_W +: ADDR_W]
//  rdata       out  NREAD*DATA_W    read data, port p at [p*DATA_W +: DATA_W]
//  rd_en       in   NREAD           port p actually consumes its operand (gates stall)
//  fwd_wreg    in   NFWD            source s will write a register
//  fwd_waddr   in   NFWD*ADDR_W     destination of source s
//  fwd_wdata   in   NFWD*DATA_W     result of source s
//  fwd_dvalid  in   NFWD            fwd_wdata of s is final (0 = load still in flight)
//  we          in   1               WB write enable
//  waddr       in   ADDR_W          WB destination
//  wdata       in   DATA_W          WB data
//  ld_issue    in   1               a load leaves ID this cycle
//  ld_waddr    in   ADDR_W          destination of that load
//  ld_kill     in   1               an in-flight load was squashed
//  ld_kaddr    in   ADDR_W          destination of the squashed load
//  stall       out  1               ID must hold (load-use hazard)
//  stall_cnt   out  32              saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset (resetn=0, async): all NREG registers <= 0, all pending bits <= 0, stall_cnt <= 0.
//   rdata/stall are combinational; with all forward/write inputs idle they read 0 / 0.
//  Write: rising edge with we=1 and waddr!=0 -> reg[waddr] <= wdata; waddr=0 writes ignored.
//  Read port p (zero latency), first match wins:
//   1 raddr==0 -> 0
//   2 lowest s with fwd_wreg[s] && fwd_waddr[s]==raddr && fwd_waddr[s]!=0 -> fwd_wdata[s]
//   3 we && waddr==raddr -> wdata (write-through, same cycle)
//   4 reg[raddr]
//  Hazard for port p: rd_en[p] && raddr!=0 && either
//   - rule-2 winner has fwd_dvalid=0, or
//   - pending[raddr]=1 and no rule-2 match and not rule-3 hit.
//   stall = OR of hazards over all ports. Younger valid source masks older invalid one.
//  Scoreboard pending[NREG] (bit 0 constant 0), per edge, in this order of precedence:
//   set   : ld_issue && ld_waddr!=0 && !stall -> pending[ld_waddr] <= 1 (wins over clear)
//   clear : we && waddr matches -> 0;  ld_kill && ld_kaddr matches -> 0
//   ld_issue while stall=1 is ignored (the load did not leave ID).
//  stall_cnt: +1 each edge with stall=1; holds at 32'hFFFF_FFFF (no wrap).
//  Reset asserted mid-stall: stall drops once pending clears; in-flight forwards are still honoured.
// STRUCTURE
//  defines.vh: `RF_ZERO_ADDR, default widths, forward-source index constants (`FWD_EX, `FWD_MEM).
//  Sub-module rf_port_sel: one read port's priority mux + hazard term; generate NREAD instances.
//  Top holds the array, scoreboard, stall OR-reduction and counter.
// TESTING
//  1 reset, then read r0..r31 on both ports -> all 0, stall=0, stall_cnt=0.
//  2 we=1,waddr=5,wdata=32'h1234 same cycle raddr0=5 -> rdata0=1234 now; next cycle from array.
//  3 fwd0 (r7,AAAA,valid) and fwd1 (r7,BBBB,valid), WB r7=CCCC -> rdata=AAAA; drop fwd0 -> BBBB.
//  4 ld_issue r9; next cycle fwd0 r9 dvalid=0 with raddr1=9,rd_en=1 -> stall=1, stall_cnt increments;
//    then fwd1 r9 dvalid=1 -> stall=0, rdata1 = fwd1_wdata; WB r9 -> pending[9] cleared.
//  5 ld_issue r3 and WB r3 same edge -> pending[3]=1; ld_kill r3 later -> read r3 no stall.
//  6 raddr=9 pending but rd_en=0 -> stall=0; fwd targeting r0 with dvalid=0 -> rdata=0, no stall.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// regfile_bypass_pkg: shared defaults and forward-source indices for the ID-stage register file
package regfile_bypass_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREAD_DEF = 2;
  localparam int NFWD_DEF = 2;
  localparam int ZERO_ADDR = 0;
  localparam int FWD_EX = 0;
  localparam int FWD_MEM = 1;
endpackage

// File: rtl/regfile_bypass_port_sel.sv
// regfile_bypass_port_sel: one read port's priority mux (zero, forward, write-through, array) and hazard term
module regfile_bypass_port_sel
  import regfile_bypass_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NFWD = NFWD_DEF
) (
  input  logic [ADDR_W-1:0]      raddr,
  input  logic                   rd_en,
  input  logic [NFWD-1:0]        fwd_wreg,
  input  logic [NFWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata,
  input  logic [NFWD-1:0]        fwd_dvalid,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   pending,
  output logic [DATA_W-1:0]      rdata,
  output logic                   hazard
);
  logic fwd_hit, fwd_ok, wb_hit, zero;
  logic [DATA_W-1:0] fwd_val;
  always_comb begin
    fwd_hit = 1'b0;
    fwd_ok = 1'b1;
    fwd_val = '0;
    // scan oldest to youngest so the youngest match is left standing
    for (int s = NFWD - 1; s >= 0; s--)
      if (fwd_wreg[s] && fwd_waddr[s*ADDR_W +: ADDR_W] == raddr && fwd_waddr[s*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_ADDR)) begin
        fwd_hit = 1'b1;
        fwd_val = fwd_wdata[s*DATA_W +: DATA_W];
        fwd_ok = fwd_dvalid[s];
      end
    zero = raddr == ADDR_W'(ZERO_ADDR);
    wb_hit = we && waddr == raddr;
    rdata = zero ? '0 : fwd_hit ? fwd_val : wb_hit ? wdata : reg_data;
    hazard = rd_en && !zero && (fwd_hit ? !fwd_ok : pending && !wb_hit);
  end
endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: GPR array with forwarding read ports, load scoreboard, stall request and stall counter
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD = NREAD_DEF,
  parameter int NFWD = NFWD_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic [NREAD-1:0]        rd_en,
  input  logic [NFWD-1:0]         fwd_wreg,
  input  logic [NFWD*ADDR_W-1:0]  fwd_waddr,
  input  logic [NFWD*DATA_W-1:0]  fwd_wdata,
  input  logic [NFWD-1:0]         fwd_dvalid,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    ld_issue,
  input  logic [ADDR_W-1:0]       ld_waddr,
  input  logic                    ld_kill,
  input  logic [ADDR_W-1:0]       ld_kaddr,
  output logic                    stall,
  output logic [31:0]             stall_cnt
);
  localparam int NREG = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREAD-1:0] hazard;
  genvar p;
  generate
    for (p = 0; p < NREAD; p++) begin : g_port
      regfile_bypass_port_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NFWD(NFWD)) u_sel (
        .raddr(raddr[p*ADDR_W +: ADDR_W]),
        .rd_en(rd_en[p]),
        .fwd_wreg(fwd_wreg),
        .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata),
        .fwd_dvalid(fwd_dvalid),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .reg_data(regs[raddr[p*ADDR_W +: ADDR_W]]),
        .pending(pending[raddr[p*ADDR_W +: ADDR_W]]),
        .rdata(rdata[p*DATA_W +: DATA_W]),
        .hazard(hazard[p])
      );
    end
  endgenerate
  assign stall = |hazard;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
      stall_cnt <= '0;
    end else begin
      if (we && waddr != ADDR_W'(ZERO_ADDR)) regs[waddr] <= wdata;
      // an issuing load wins over a same-edge WB or kill of that register
      for (int i = 1; i < NREG; i++)
        if (ld_issue && !stall && ld_waddr == ADDR_W'(i)) pending[i] <= 1'b1;
        else if ((we && waddr == ADDR_W'(i)) || (ld_kill && ld_kaddr == ADDR_W'(i))) pending[i] <= 1'b0;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: directed and random stimulus checked against a behavioural register-file model
module tb_regfile_bypass;
  localparam int DW = 32, AW = 5, NR = 2, NF = 2;
  logic clk = 1'b0, resetn;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rd_en;
  logic [NF-1:0] fwd_wreg, fwd_dvalid;
  logic [NF*AW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;
  logic we, ld_issue, ld_kill, stall;
  logic [AW-1:0] waddr, ld_waddr, ld_kaddr;
  logic [DW-1:0] wdata;
  logic [31:0] stall_cnt;
  logic [31:0] mem [32];
  bit pend [32];
  logic [31:0] cnt;
  int n_checks = 0, n_pass = 0;

  regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NFWD(NF)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rd_en(rd_en),
    .fwd_wreg(fwd_wreg), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_dvalid(fwd_dvalid),
    .we(we), .waddr(waddr), .wdata(wdata), .ld_issue(ld_issue), .ld_waddr(ld_waddr),
    .ld_kill(ld_kill), .ld_kaddr(ld_kaddr), .stall(stall), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic int match(int a);
    for (int s = 0; s < NF; s++)
      if (fwd_wreg[s] && int'(fwd_waddr[s*AW +: AW]) == a && a != 0) return s;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(int p);
    int a = int'(raddr[p*AW +: AW]);
    int s = match(a);
    if (a == 0) return 0;
    if (s >= 0) return fwd_wdata[s*DW +: DW];
    if (we && int'(waddr) == a) return wdata;
    return mem[a];
  endfunction

  function automatic logic exp_stall();
    logic st = 1'b0;
    for (int p = 0; p < NR; p++) begin
      int a = int'(raddr[p*AW +: AW]);
      int s = match(a);
      if (rd_en[p] && a != 0)
        st |= (s >= 0) ? !fwd_dvalid[s] : (pend[a] && !(we && int'(waddr) == a));
    end
    return st;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
    cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  task automatic idle();
    raddr = '0; rd_en = '0; fwd_wreg = '0; fwd_dvalid = '0; fwd_waddr = '0; fwd_wdata = '0;
    we = 0; waddr = 0; wdata = 0; ld_issue = 0; ld_waddr = 0; ld_kill = 0; ld_kaddr = 0;
  endtask

  task automatic check_outputs(input string tag);
    #1;
    for (int p = 0; p < NR; p++) chk($sformatf("%s_rdata%0d", tag, p), rdata[p*DW +: DW], exp_rd(p));
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, exp_stall()});
  endtask

  task automatic tick();
    logic st = exp_stall();
    @(posedge clk);
    if (we && waddr != 0) mem[waddr] = wdata;
    if (we) pend[waddr] = 0;
    if (ld_kill) pend[ld_kaddr] = 0;
    if (ld_issue && ld_waddr != 0 && !st) pend[ld_waddr] = 1;
    pend[0] = 0;
    if (st && cnt != 32'hFFFF_FFFF) cnt++;
    #1 chk("stall_cnt", stall_cnt, cnt);
    @(negedge clk);
  endtask

  task automatic set_fwd(input int s, input logic w, input int a, input logic [31:0] d, input logic v);
    fwd_wreg[s] = w; fwd_waddr[s*AW +: AW] = AW'(a); fwd_wdata[s*DW +: DW] = d; fwd_dvalid[s] = v;
  endtask

  initial begin
    idle();
    model_reset();
    resetn = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_cnt", stall_cnt, 32'd0);
    resetn = 1;
    for (int a = 0; a < 32; a++) begin
      raddr = {AW'(a), AW'(a)}; rd_en = 2'b11;
      check_outputs("reset_read");
    end
    idle(); we = 1; waddr = 5; wdata = 32'h1234; raddr[0 +: AW] = 5; rd_en = 2'b01;
    check_outputs("wt_same");
    tick();
    we = 0;
    check_outputs("wt_array");
    idle(); raddr = {AW'(7), AW'(7)}; rd_en = 2'b11;
    set_fwd(0, 1, 7, 32'hAAAA, 1); set_fwd(1, 1, 7, 32'hBBBB, 1);
    we = 1; waddr = 7; wdata = 32'hCCCC;
    check_outputs("fwd_prio");
    tick();
    we = 0; fwd_wreg[0] = 0;
    check_outputs("fwd_older");
    idle(); ld_issue = 1; ld_waddr = 9;
    tick();
    idle(); raddr[AW +: AW] = 9; rd_en = 2'b10; set_fwd(0, 1, 9, 32'h1111, 0);
    check_outputs("ld_use_stall");
    tick();
    set_fwd(0, 0, 0, 0, 0); set_fwd(1, 1, 9, 32'h9999, 1);
    check_outputs("ld_fwd_valid");
    tick();
    idle(); we = 1; waddr = 9; wdata = 32'h9999;
    tick();
    idle(); raddr[AW +: AW] = 9; rd_en = 2'b10;
    check_outputs("ld_wb_clear");
    idle(); ld_issue = 1; ld_waddr = 3; we = 1; waddr = 3; wdata = 32'h33;
    tick();
    idle(); raddr[0 +: AW] = 3; rd_en = 2'b01;
    check_outputs("set_wins");
    ld_kill = 1; ld_kaddr = 3;
    tick();
    ld_kill = 0;
    check_outputs("kill_clear");
    idle(); ld_issue = 1; ld_waddr = 9;
    tick();
    idle(); raddr = {AW'(9), AW'(9)}; rd_en = 2'b00;
    check_outputs("pend_no_rden");
    raddr = '0; rd_en = 2'b11; set_fwd(0, 1, 0, 32'hDEAD, 0);
    check_outputs("fwd_r0");
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
      rd_en = NR'($urandom);
      for (int s = 0; s < NF; s++) set_fwd(s, 1'($urandom), $urandom_range(0, 7), $urandom, 1'($urandom_range(0, 3) != 0));
      we = 1'($urandom); waddr = AW'($urandom_range(0, 7)); wdata = $urandom;
      ld_issue = 1'($urandom); ld_waddr = AW'($urandom_range(0, 7));
      ld_kill = 1'($urandom_range(0, 3) == 0); ld_kaddr = AW'($urandom_range(0, 7));
      check_outputs("rand");
      tick();
    end
    idle(); ld_issue = 1; ld_waddr = 4;
    tick();
    idle(); raddr[0 +: AW] = 4; rd_en = 2'b01;
    check_outputs("pre_reset_stall");
    tick();
    resetn = 0;
    model_reset();
    set_fwd(0, 1, 4, 32'h55, 1);
    check_outputs("reset_fwd");
    chk("reset_cnt_mid", stall_cnt, 32'd0);
    @(negedge clk);
    resetn = 1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
